ipv4_hdr_sequencer: RTL and testbench

- Front-end controller for the IPv4 header segmentation/checker block.
- Accepts a 32-bit word stream (valid/ready/last) and assembles the five header words plus one data word onto the checker's parallel ih1..ih6 inputs.
- Pulses a per-packet clear into the checker, then waits for its valid/invalid verdict with a timeout.
- Returns one result code per packet through a valid/ready handshake and keeps statistics counters.

---
 rtl/ipv4_hdr_sequencer_pkg.sv | 24 ++
 rtl/ipv4_hdr_sequencer_sat_counter.sv | 26 ++
 rtl/ipv4_hdr_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ipv4_hdr_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_hdr_sequencer_pkg.sv
// Shared constants for the IPv4 header sequencer: FSM state encodings,
// result codes and default sizing.
package ipv4_seq_pkg;

    localparam int WORDS_DEF   = 6;
    localparam int TIMEOUT_DEF = 64;
    localparam int IH_N        = 6;

    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_CLEAR   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_REPORT  = 3'd4;

    localparam logic [1:0] RES_PASS    = 2'd0;
    localparam logic [1:0] RES_FAIL    = 2'd1;
    localparam logic [1:0] RES_TIMEOUT = 2'd2;
    localparam logic [1:0] RES_FRAME   = 2'd3;

    function automatic logic is_error(input logic [1:0] code);
        return (code != RES_PASS);
    endfunction

endpackage

// File: rtl/ipv4_hdr_sequencer_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count up on inc, holding once saturated.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ipv4_hdr_sequencer.sv
// Collects a packet of 32-bit words onto the checker's parallel inputs,
// clears the checker, waits for its verdict and reports one code per packet.
module ipv4_hdr_sequencer
    import ipv4_seq_pkg::*;
#(
    parameter int WORDS       = WORDS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [31:0]      ih1,
    output logic [31:0]      ih2,
    output logic [31:0]      ih3,
    output logic [31:0]      ih4,
    output logic [31:0]      ih5,
    output logic [31:0]      ih6,
    output logic             chk_clr,
    input  logic             chk_valid,
    input  logic             chk_invalid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_code,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [1:0]       code_q, code_d;
    logic             s_ready_q, chk_clr_q, res_valid_q;
    logic [31:0]      ih_q [IH_N];
    logic             s_fire, res_fire;

    assign s_fire   = s_valid & s_ready_q;
    assign res_fire = res_valid_q & res_ready;

    // Next-state logic for the packet FSM, word index, timeout and result code.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        to_d    = to_q;
        code_d  = code_q;
        case (state_q)
            ST_COLLECT: begin
                if (s_fire) begin
                    if (s_last) begin
                        idx_d = {IDX_W{1'b0}};
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_CLEAR;
                        end else begin
                            state_d = ST_REPORT;
                            code_d  = RES_FRAME;
                        end
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_DRAIN;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DRAIN: begin
                if (s_fire && s_last) begin
                    state_d = ST_REPORT;
                    code_d  = RES_FRAME;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                state_d = ST_WAIT;
                to_d    = TO_LOAD;
            end
            ST_WAIT: begin
                // Invalid outranks valid when the checker raises both.
                if (chk_invalid) begin
                    state_d = ST_REPORT;
                    code_d  = RES_FAIL;
                end else if (chk_valid) begin
                    state_d = ST_REPORT;
                    code_d  = RES_PASS;
                end else if (to_q == {TO_W{1'b0}}) begin
                    state_d = ST_REPORT;
                    code_d  = RES_TIMEOUT;
                end else begin
                    to_d = to_q - TO_ONE;
                end
            end
            ST_REPORT: begin
                if (res_fire) begin
                    state_d = ST_COLLECT;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, handshake outputs and the header word register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            idx_q       <= {IDX_W{1'b0}};
            to_q        <= {TO_W{1'b0}};
            code_q      <= RES_PASS;
            s_ready_q   <= 1'b0;
            chk_clr_q   <= 1'b1;
            res_valid_q <= 1'b0;
            for (int i = 0; i < IH_N; i++) begin
                ih_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            to_q        <= to_d;
            code_q      <= code_d;
            s_ready_q   <= (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
            chk_clr_q   <= (state_d == ST_CLEAR);
            res_valid_q <= (state_d == ST_REPORT);
            for (int i = 0; i < IH_N; i++) begin
                if ((state_q == ST_COLLECT) && s_fire && (int'(idx_q) == i)) begin
                    ih_q[i] <= s_data;
                end else begin
                    ih_q[i] <= ih_q[i];
                end
            end
        end
    end

    assign s_ready   = s_ready_q;
    assign chk_clr   = chk_clr_q;
    assign res_valid = res_valid_q;
    assign res_code  = code_q;
    assign ih1 = ih_q[0];
    assign ih2 = ih_q[1];
    assign ih3 = ih_q[2];
    assign ih4 = ih_q[3];
    assign ih5 = ih_q[4];
    assign ih6 = ih_q[5];

    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (res_fire),
        .count (pkt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (res_fire && !is_error(code_q)),
        .count (pass_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (res_fire && is_error(code_q)),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_ipv4_hdr_sequencer.sv
// Directed bench for ipv4_hdr_sequencer; a second copy with 2-bit counters
// sees the same traffic so counter saturation is reached quickly.
module tb_ipv4_hdr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_data;
    logic        s_valid, s_last, chk_valid, chk_invalid, res_ready;
    logic        s_ready, chk_clr, res_valid;
    logic [31:0] ih1, ih2, ih3, ih4, ih5, ih6;
    logic [1:0]  res_code;
    logic [15:0] pkt_cnt, pass_cnt, err_cnt;

    logic        sm_s_ready, sm_chk_clr, sm_res_valid;
    logic [31:0] sm_ih1, sm_ih2, sm_ih3, sm_ih4, sm_ih5, sm_ih6;
    logic [1:0]  sm_res_code;
    logic [1:0]  sm_pkt_cnt, sm_pass_cnt, sm_err_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          clr_total = 0;
    int          base;
    int          n;
    logic [31:0] pkt [8];

    always #5 clk = ~clk;

    ipv4_hdr_sequencer #(.WORDS(6), .TIMEOUT_CYC(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .ih1(ih1), .ih2(ih2), .ih3(ih3),
        .ih4(ih4), .ih5(ih5), .ih6(ih6), .chk_clr(chk_clr),
        .chk_valid(chk_valid), .chk_invalid(chk_invalid),
        .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .pkt_cnt(pkt_cnt), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
    );

    ipv4_hdr_sequencer #(.WORDS(6), .TIMEOUT_CYC(64), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(sm_s_ready), .ih1(sm_ih1), .ih2(sm_ih2),
        .ih3(sm_ih3), .ih4(sm_ih4), .ih5(sm_ih5), .ih6(sm_ih6),
        .chk_clr(sm_chk_clr), .chk_valid(chk_valid), .chk_invalid(chk_invalid),
        .res_valid(sm_res_valid), .res_ready(res_ready), .res_code(sm_res_code),
        .pkt_cnt(sm_pkt_cnt), .pass_cnt(sm_pass_cnt), .err_cnt(sm_err_cnt)
    );

    // Counts clock edges at which the checker clear is high outside reset.
    always @(posedge clk) begin
        if (chk_clr && !reset) clr_total = clr_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            s_data  = pkt[i];
            s_valid = 1'b1;
            s_last  = (i == cnt - 1);
            for (int k = 0; k < 20 && !s_ready; k++) cyc();
            check("word_ready", 32'(s_ready), 32'd1);
            cyc();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    task automatic load_pkt(input logic [31:0] seed);
        for (int i = 0; i < 8; i++) pkt[i] = seed + 32'(i) * 32'h0101_0101;
    endtask

    task automatic run_pass_pkt();
        send_pkt(6);
        chk_valid = 1'b1;
        cyc();
        cyc();
        chk_valid = 1'b0;
        check("quick_res_valid", 32'(res_valid), 32'd1);
        check("quick_res_code", 32'(res_code), 32'd0);
        accept();
    endtask

    initial begin
        reset = 1'b1; s_data = 32'h0; s_valid = 1'b0; s_last = 1'b0;
        chk_valid = 1'b0; chk_invalid = 1'b0; res_ready = 1'b0;
        cyc();
        cyc();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_chk_clr", 32'(chk_clr), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_code", 32'(res_code), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_ih1", ih1, 32'h0);
        reset = 1'b0;
        cyc();
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_chk_clr", 32'(chk_clr), 32'd0);

        // Pass packet, checker answers 14 cycles after the clear.
        pkt[0] = 32'h4501_0018; pkt[1] = 32'h0000_4000; pkt[2] = 32'h7B06_FCED;
        pkt[3] = 32'hC000_0001; pkt[4] = 32'hC400_0001; pkt[5] = 32'hC400_0007;
        base = clr_total;
        send_pkt(6);
        check("pass_clr_now", 32'(chk_clr), 32'd1);
        check("pass_s_ready", 32'(s_ready), 32'd0);
        repeat (13) cyc();
        check("pass_no_early_res", 32'(res_valid), 32'd0);
        chk_valid = 1'b1;
        cyc();
        chk_valid = 1'b0;
        check("pass_clr_once", 32'(clr_total - base), 32'd1);
        check("pass_res_valid", 32'(res_valid), 32'd1);
        check("pass_res_code", 32'(res_code), 32'd0);
        check("pass_ih1", ih1, 32'h4501_0018);
        check("pass_ih6", ih6, 32'hC400_0007);
        accept();
        check("pass_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("pass_pass_cnt", 32'(pass_cnt), 32'd1);
        check("pass_res_valid_drop", 32'(res_valid), 32'd0);

        // Short packet: s_last on the third word.
        load_pkt(32'h1100_0000);
        base = clr_total;
        send_pkt(3);
        cyc();
        check("short_no_clr", 32'(clr_total - base), 32'd0);
        check("short_res_valid", 32'(res_valid), 32'd1);
        check("short_res_code", 32'(res_code), 32'd3);
        accept();
        check("short_err_cnt", 32'(err_cnt), 32'd1);

        // Normal packet after the short one; an invalid flag during CLEAR is ignored.
        load_pkt(32'h2200_0010);
        send_pkt(6);
        check("norm_ih1", ih1, 32'h2200_0010);
        check("norm_ih3", ih3, 32'h2402_0212);
        check("norm_ih6", ih6, 32'h2705_0515);
        chk_invalid = 1'b1;
        cyc();
        chk_invalid = 1'b0;
        chk_valid = 1'b1;
        cyc();
        chk_valid = 1'b0;
        check("norm_res_valid", 32'(res_valid), 32'd1);
        check("norm_res_code", 32'(res_code), 32'd0);
        accept();
        check("norm_pass_cnt", 32'(pass_cnt), 32'd2);

        // Long packet: words 7 and 8 drained.
        load_pkt(32'h3300_0020);
        base = clr_total;
        send_pkt(8);
        check("long_res_valid", 32'(res_valid), 32'd1);
        check("long_res_code", 32'(res_code), 32'd3);
        check("long_ih1", ih1, 32'h3300_0020);
        check("long_ih6", ih6, 32'h3805_0525);
        check("long_no_clr", 32'(clr_total - base), 32'd0);
        accept();
        check("long_err_cnt", 32'(err_cnt), 32'd2);

        // Timeout: 1 CLEAR cycle then 64 WAIT cycles.
        load_pkt(32'h4400_0030);
        send_pkt(6);
        n = 0;
        while (!res_valid && n < 200) begin
            cyc();
            n++;
        end
        check("to_latency", 32'(n), 32'd65);
        check("to_res_code", 32'(res_code), 32'd2);
        accept();
        check("to_err_cnt", 32'(err_cnt), 32'd3);

        // Both flags at once, then a 5-cycle stall on res_ready.
        load_pkt(32'h5500_0040);
        send_pkt(6);
        cyc();
        chk_valid = 1'b1;
        chk_invalid = 1'b1;
        cyc();
        chk_valid = 1'b0;
        chk_invalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_code", 32'(res_code), 32'd1);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_pkt_cnt", 32'(pkt_cnt), 32'd5);
            check("stall_err_cnt", 32'(err_cnt), 32'd3);
            cyc();
        end
        accept();
        check("both_pkt_cnt", 32'(pkt_cnt), 32'd6);
        check("both_err_cnt", 32'(err_cnt), 32'd4);
        check("both_pass_cnt", 32'(pass_cnt), 32'd2);
        check("sat_pkt_small", 32'(sm_pkt_cnt), 32'd3);
        check("sat_err_small", 32'(sm_err_cnt), 32'd3);
        check("sat_pass_small", 32'(sm_pass_cnt), 32'd2);

        // Reset while waiting on the checker.
        load_pkt(32'h6600_0050);
        send_pkt(6);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_chk_clr", 32'(chk_clr), 32'd1);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_code", 32'(res_code), 32'd0);
        check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_ih1", ih1, 32'h0);
        reset = 1'b0;
        cyc();
        chk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("aborted_no_res", 32'(res_valid), 32'd0);
        end
        chk_valid = 1'b0;
        check("aborted_s_ready", 32'(s_ready), 32'd1);

        // Saturation of the 2-bit counters.
        for (int i = 0; i < 4; i++) begin
            load_pkt(32'h7700_0000 + 32'(i));
            run_pass_pkt();
        end
        check("sat_pkt_cnt", 32'(pkt_cnt), 32'd4);
        check("sat_pass_cnt", 32'(pass_cnt), 32'd4);
        check("sat_pkt_small_hold", 32'(sm_pkt_cnt), 32'd3);
        check("sat_pass_small_hold", 32'(sm_pass_cnt), 32'd3);
        check("sat_err_small_zero", 32'(sm_err_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
